// File: rtl/ipm_sync_router_port_if.sv
// Link bundle for the synchronous router input port:
// upstream flit handshake plus per-output downstream handshake and lock.
interface ipm_sync_router_port_if #(
    parameter int WIDTH    = 32,
    parameter int OUTPORTS = 5
);
    logic                               valid_up_i;
    logic [WIDTH-1:0]                   Data_up_i;
    logic                               ready_up_o;
    logic [OUTPORTS-1:0]                valid_dw_o;
    logic [OUTPORTS-1:0][WIDTH-1:0]     Data_dw_o;
    logic [OUTPORTS-1:0]                ready_dw_i;
    logic [OUTPORTS-1:0]                PacketEnable_dw_o;
    logic                               err_o;

    modport slave (
        input  valid_up_i,
        input  Data_up_i,
        output ready_up_o,
        output valid_dw_o,
        output Data_dw_o,
        input  ready_dw_i,
        output PacketEnable_dw_o,
        output err_o
    );

    modport master (
        output valid_up_i,
        output Data_up_i,
        input  ready_up_o,
        input  valid_dw_o,
        input  Data_dw_o,
        output ready_dw_i,
        input  PacketEnable_dw_o,
        input  err_o
    );
endinterface

// File: rtl/ipm_sync_router_port.sv
// Synchronous NoC router input port: DEPTH-entry flit FIFO, XY routing, wormhole lock.
// Optional IPM_STATS_EN adds per-port packet counters and a saturating drop counter.
module ipm_sync_router_port #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int OUTPORTS  = 5,
    parameter int CW        = 4,
    parameter int LocationX = 2,
    parameter int LocationY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    ipm_sync_router_port_if.slave        port_if
`ifdef IPM_STATS_EN
    ,
    output logic [OUTPORTS-1:0][15:0]    pkt_cnt_o,
    output logic [15:0]                  drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] LX = CW'(LocationX);
    localparam logic [CW-1:0] LY = CW'(LocationY);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [OUTPORTS-1:0] r_sel;
    logic [OUTPORTS-1:0] w_sel_nxt;
    logic [OUTPORTS-1:0] w_route;
    logic [OUTPORTS-1:0] w_valid;
    logic [OUTPORTS-1:0] w_pe;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_err;
    logic [WIDTH-1:0]    w_head;
    logic [1:0]          w_type;
    logic [CW-1:0]       w_dx;
    logic [CW-1:0]       w_dy;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = port_if.valid_up_i && port_if.ready_up_o;
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_type  = w_head[WIDTH-1:WIDTH-2];
    assign w_dx    = w_head[2*CW-1:CW];
    assign w_dy    = w_head[CW-1:0];

    // Ready is held low while reset is asserted; it is not pop-aware.
    assign port_if.ready_up_o        = reset && !w_full;
    assign port_if.Data_dw_o         = {OUTPORTS{w_head}};
    assign port_if.valid_dw_o        = w_valid;
    assign port_if.PacketEnable_dw_o = w_pe;
    assign port_if.err_o             = w_err;

    // XY route of the FIFO head: resolve X first, then Y, else local.
    always_comb begin
        w_route = '0;
        priority case (1'b1)
            (w_dx > LX): w_route[1] = 1'b1;
            (w_dx < LX): w_route[3] = 1'b1;
            (w_dy > LY): w_route[0] = 1'b1;
            (w_dy < LY): w_route[2] = 1'b1;
            default:     w_route[4] = 1'b1;
        endcase
    end

    // Lock FSM: route heads, discard strays, stream flits until the tail leaves.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pop       = 1'b0;
        w_err       = 1'b0;
        w_valid     = '0;
        w_pe        = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_type[1]) begin
                        w_sel_nxt   = w_route;
                        w_state_nxt = S_LOCK;
                    end else begin
                        w_pop = 1'b1;
                        w_err = 1'b1;
                    end
                end
            end
            S_LOCK: begin
                w_pe    = r_sel;
                w_valid = w_empty ? '0 : r_sel;
                w_pop   = |(w_valid & port_if.ready_dw_i);
                if (w_pop && w_type[0]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state and locked output selection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Flit storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= port_if.Data_up_i;
        end
    end

`ifdef IPM_STATS_EN
    logic [OUTPORTS-1:0][15:0] r_pkt_cnt;
    logic [15:0]               r_drop_cnt;
    logic                      w_tail_pop;

    assign w_tail_pop = (r_state == S_LOCK) && w_pop && w_type[0];
    assign pkt_cnt_o  = r_pkt_cnt;
    assign drop_cnt_o = r_drop_cnt;

    // Per-port wrapping packet count and saturating drop count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < OUTPORTS; i++) begin
                if (w_tail_pop && r_sel[i]) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
                end
            end
            if (w_err && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipm_sync_router_port.sv
// Self-checking bench for ipm_sync_router_port at Location (2,2).
// Scoreboard of expected (flit, port) pairs checked by a delivery monitor.
module tb_ipm_sync_router_port;

    typedef struct {
        logic [31:0] data;
        int          port;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    exp_t mon_e;
    logic [4:0] mon_hs;

`ifdef IPM_STATS_EN
    logic [4:0][15:0] pkt_cnt;
    logic [15:0]      drop_cnt;
`endif

    ipm_sync_router_port_if #(.WIDTH(32), .OUTPORTS(5)) bus ();

    ipm_sync_router_port #(
        .WIDTH(32), .DEPTH(4), .OUTPORTS(5), .CW(4),
        .LocationX(2), .LocationY(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .port_if (bus)
`ifdef IPM_STATS_EN
        ,
        .pkt_cnt_o  (pkt_cnt),
        .drop_cnt_o (drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] flit(input logic [1:0] t, input logic [3:0] x,
                                         input logic [3:0] y, input logic [21:0] pl);
        return {t, pl, x, y};
    endfunction

    function automatic exp_t mk(input logic [31:0] d, input int p);
        exp_t e;
        e.data = d;
        e.port = p;
        return e;
    endfunction

    // Delivery monitor: every downstream handshake must match the scoreboard head.
    always @(negedge clk) begin
        mon_hs = bus.valid_dw_o & bus.ready_dw_i;
        if (reset && (mon_hs != 5'b0)) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL deliver_unexpected: got valid %b data %h, expected none",
                         bus.valid_dw_o, bus.Data_dw_o[0]);
            end else begin
                mon_e = sb.pop_front();
                if ((bus.valid_dw_o !== (5'b1 << mon_e.port)) ||
                    (bus.Data_dw_o[mon_e.port] !== mon_e.data)) begin
                    $display("FAIL deliver: got valid %b data %h, expected valid %b data %h",
                             bus.valid_dw_o, bus.Data_dw_o[mon_e.port],
                             5'b1 << mon_e.port, mon_e.data);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic send(input logic [31:0] f);
        bit ok;
        ok = 1'b0;
        bus.valid_up_i = 1'b1;
        bus.Data_up_i  = f;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = bus.ready_up_o;
            @(posedge clk);
            #1;
        end
        bus.valid_up_i = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL send_timeout: got ready_up_o 0, expected 1 within 60 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.PacketEnable_dw_o == 5'b0 &&
                bus.valid_dw_o == 5'b0) break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.valid_up_i = 1'b0;
        bus.Data_up_i  = '0;
        bus.ready_dw_i = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b0) $display("FAIL rst_ready: got %b expected 0", bus.ready_up_o);
        else n_pass++;
        n_total++;
        if (bus.valid_dw_o !== 5'b0) $display("FAIL rst_valid: got %b expected 00000", bus.valid_dw_o);
        else n_pass++;
        n_total++;
        if (bus.PacketEnable_dw_o !== 5'b0)
            $display("FAIL rst_pe: got %b expected 00000", bus.PacketEnable_dw_o);
        else n_pass++;
        n_total++;
        if (bus.err_o !== 1'b0) $display("FAIL rst_err: got %b expected 0", bus.err_o);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", bus.ready_up_o);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [31:0] f;
        bus.ready_dw_i = 5'b11111;
        f = flit(2'b11, 4'd3, 4'd2, 22'h0A5A5);
        sb.push_back(mk(f, 1));
        bus.valid_up_i = 1'b1;
        bus.Data_up_i  = f;
        @(posedge clk);
        #1;
        bus.valid_up_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.valid_dw_o !== 5'b0) $display("FAIL single_early: got %b expected 00000", bus.valid_dw_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.valid_dw_o !== 5'b00010) $display("FAIL single_valid: got %b expected 00010", bus.valid_dw_o);
        else n_pass++;
        n_total++;
        if (bus.PacketEnable_dw_o !== 5'b00010)
            $display("FAIL single_pe: got %b expected 00010", bus.PacketEnable_dw_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.PacketEnable_dw_o !== 5'b0 || bus.valid_dw_o !== 5'b0)
            $display("FAIL single_release: got pe %b valid %b expected 00000 00000",
                     bus.PacketEnable_dw_o, bus.valid_dw_o);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] fl [5];
        bus.ready_dw_i = 5'b11011;
        fl[0] = flit(2'b10, 4'd2, 4'd0, 22'h00001);
        fl[1] = flit(2'b00, 4'h1, 4'h1, 22'h11111);
        fl[2] = flit(2'b00, 4'h2, 4'h2, 22'h22222);
        fl[3] = flit(2'b00, 4'h3, 4'h3, 22'h33333);
        fl[4] = flit(2'b01, 4'h4, 4'h4, 22'h3FFFF);
        for (int i = 0; i < 5; i++) sb.push_back(mk(fl[i], 2));
        for (int i = 0; i < 4; i++) send(fl[i]);
        @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b0) $display("FAIL bp_full: got %b expected 0", bus.ready_up_o);
        else n_pass++;
        n_total++;
        if (bus.valid_dw_o !== 5'b00100 || bus.PacketEnable_dw_o !== 5'b00100)
            $display("FAIL bp_lock: got valid %b pe %b expected 00100 00100",
                     bus.valid_dw_o, bus.PacketEnable_dw_o);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        bus.valid_up_i = 1'b1;
        bus.Data_up_i  = fl[4];
        bus.ready_dw_i = 5'b11111;
        @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b0) $display("FAIL bp_still_full: got %b expected 0", bus.ready_up_o);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b1)
            $display("FAIL bp_no_pop_push: got ready %b expected 1", bus.ready_up_o);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.valid_up_i = 1'b0;
        drain();
        n_total++;
        if (sb.size() != 0) $display("FAIL bp_drain: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_drop();
        bus.ready_dw_i = 5'b11111;
        bus.valid_up_i = 1'b1;
        bus.Data_up_i  = flit(2'b00, 4'd3, 4'd2, 22'h0BEEF);
        @(posedge clk);
        #1;
        bus.valid_up_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.err_o !== 1'b1 || bus.valid_dw_o !== 5'b0)
            $display("FAIL drop_err: got err %b valid %b expected 1 00000", bus.err_o, bus.valid_dw_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.err_o !== 1'b0 || bus.valid_dw_o !== 5'b0 || bus.PacketEnable_dw_o !== 5'b0)
            $display("FAIL drop_after: got err %b valid %b pe %b expected 0 00000 00000",
                     bus.err_o, bus.valid_dw_o, bus.PacketEnable_dw_o);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] fl [5];
        logic [4:0]  vlog [30];
        logic [4:0]  plog [30];
        int          d[$];
        int          ta;
        int          tb;
        bus.ready_dw_i = 5'b11111;
        fl[0] = flit(2'b10, 4'd2, 4'd2, 22'h0A001);
        fl[1] = flit(2'b00, 4'd7, 4'd7, 22'h0A002);
        fl[2] = flit(2'b01, 4'd8, 4'd8, 22'h0A003);
        fl[3] = flit(2'b10, 4'd1, 4'd5, 22'h0B001);
        fl[4] = flit(2'b01, 4'd9, 4'd9, 22'h0B002);
        for (int i = 0; i < 3; i++) sb.push_back(mk(fl[i], 4));
        for (int i = 3; i < 5; i++) sb.push_back(mk(fl[i], 3));
        fork
            begin
                for (int i = 0; i < 5; i++) send(fl[i]);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    vlog[c] = bus.valid_dw_o;
                    plog[c] = bus.PacketEnable_dw_o;
                    if ((bus.valid_dw_o & bus.ready_dw_i) != 5'b0) d.push_back(c);
                end
            end
        join
        n_total++;
        if (d.size() != 5) begin
            $display("FAIL b2b_count: got %0d deliveries expected 5", d.size());
        end else begin
            n_pass++;
            ta = d[2];
            tb = d[3];
            n_total++;
            if (tb - ta != 2) $display("FAIL b2b_gap: got %0d cycles expected 2", tb - ta);
            else n_pass++;
            n_total++;
            if (vlog[ta] !== 5'b10000 || vlog[tb] !== 5'b01000)
                $display("FAIL b2b_ports: got %b then %b expected 10000 then 01000", vlog[ta], vlog[tb]);
            else n_pass++;
            n_total++;
            if (vlog[ta+1] !== 5'b0 || plog[ta+1] !== 5'b0)
                $display("FAIL b2b_idle: got valid %b pe %b expected 00000 00000",
                         vlog[ta+1], plog[ta+1]);
            else n_pass++;
        end
        drain();
        n_total++;
        if (sb.size() != 0) $display("FAIL b2b_drain: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] f;
        bus.ready_dw_i = 5'b00000;
        send(flit(2'b10, 4'd3, 4'd2, 22'h0C001));
        send(flit(2'b00, 4'd0, 4'd0, 22'h0C002));
        send(flit(2'b00, 4'd0, 4'd0, 22'h0C003));
        @(negedge clk);
        n_total++;
        if (bus.PacketEnable_dw_o !== 5'b00010)
            $display("FAIL mid_lock: got %b expected 00010", bus.PacketEnable_dw_o);
        else n_pass++;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_total++;
        if (bus.ready_up_o !== 1'b0 || bus.valid_dw_o !== 5'b0 ||
            bus.PacketEnable_dw_o !== 5'b0)
            $display("FAIL mid_reset: got ready %b valid %b pe %b expected 0 00000 00000",
                     bus.ready_up_o, bus.valid_dw_o, bus.PacketEnable_dw_o);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.ready_dw_i = 5'b11111;
        @(negedge clk);
        n_total++;
        if (bus.ready_up_o !== 1'b1 || bus.valid_dw_o !== 5'b0 || bus.err_o !== 1'b0)
            $display("FAIL mid_empty: got ready %b valid %b err %b expected 1 00000 0",
                     bus.ready_up_o, bus.valid_dw_o, bus.err_o);
        else n_pass++;
        @(posedge clk);
        #1;
        f = flit(2'b11, 4'd2, 4'd5, 22'h0D00D);
        sb.push_back(mk(f, 0));
        send(f);
        drain();
        n_total++;
        if (sb.size() != 0) $display("FAIL mid_newpkt: got %0d left expected 0", sb.size());
        else n_pass++;
    endtask

`ifdef IPM_STATS_EN
    task automatic test_stats();
        logic [31:0] f;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.ready_dw_i = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            f = flit(2'b11, 4'd2, 4'd7, 22'(i));
            sb.push_back(mk(f, 0));
            send(f);
        end
        send(flit(2'b01, 4'd1, 4'd1, 22'h0DEAD));
        drain();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (pkt_cnt[0] !== 16'd3) $display("FAIL stats_pkt_n: got %0d expected 3", pkt_cnt[0]);
        else n_pass++;
        n_total++;
        if (pkt_cnt[4] !== 16'd0) $display("FAIL stats_pkt_l: got %0d expected 0", pkt_cnt[4]);
        else n_pass++;
        n_total++;
        if (drop_cnt !== 16'd1) $display("FAIL stats_drop: got %0d expected 1", drop_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_reset_mid();
`ifdef IPM_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
